pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//   Program-counter generator for instruction fetch; successor of the 2:1 PC mux.
//   Holds the architectural PC and selects the next PC by fixed priority:
//   exception > jump-register > jump > branch > sequential (PC+INCR).
//   Supports fetch stall and buffers redirects that arrive while stalled.
//   Sits between the branch/jump resolution logic and the instruction memory address port.
// PARAMETERS
//   WIDTH       32            PC / target width in bits
//   RESET_PC    32'h0000_0000 PC value loaded on reset
//   EXC_VECTOR  32'h0000_0080 target loaded on exception request
//   INCR        4             sequential increment in bytes
// PORTS
//   clk            in   1      clock; all state updates on rising edge
//   rst_n          in   1      synchronous reset, active low
//   stall          in   1      1 = hold PC this cycle
//   exc_req        in   1      exception redirect to EXC_VECTOR
//   jr_valid       in   1      jump-register redirect
//   jr_target      in   WIDTH  jump-register target
//   jump_valid     in   1      jump redirect
//   jump_target    in   WIDTH  jump target
//   branch_valid   in   1      taken-branch redirect
//   branch_target  in   WIDTH  branch target
//   pc             out  WIDTH  current fetch address (registered)
//   pc_next_seq    out  WIDTH  pc + INCR (combinational, mod 2^WIDTH)
//   flush          out  1      registered; 1 for the cycle after a redirect is applied
//   addr_err       out  1      registered; 1 for the cycle after a misaligned target is applied
//   pend_valid     out  1      a redirect is buffered awaiting stall release
// BEHAVIOUR
//   Reset (rst_n=0 at edge): pc=RESET_PC, flush=0, addr_err=0, pending cleared;
//     reset overrides all other inputs, including mid-stall with a pending redirect.
//   Priority classes: EXC(3) > JR(2) > J(1) > BR(0). Request = highest asserted valid.
//   Pending register: {pend_valid, pend_class[1:0], pend_target}.
//   stall=1 at edge:
//     - pc holds; flush=0; addr_err=0.
//     - If a request is present and (pend_valid=0 or req class >= pend_class):
//       pending <= request (same class: newer overwrites). Lower class is dropped.
//   stall=0 at edge: candidate = higher-class of {new request, pending};
//       equal class -> new request wins.
//     - candidate exists: pc <= {target[WIDTH-1:2],2'b00}; flush<=1;
//       addr_err <= (target[1:0]!=0); pending cleared.
//     - none: pc <= pc + INCR (wraps at 2^WIDTH); flush<=0; addr_err<=0.
//   Latency: redirect asserted in cycle N with stall=0 -> pc = target in cycle N+1.
//   Redirect during stall applied on first edge with stall=0; no redirect is lost
//     unless superseded by a higher/equal class.
//   EXC target is EXC_VECTOR (never misaligned if parameter aligned).
//   pend_valid is a direct register output; 0 after reset.
// TESTING
//   1 Reset: rst_n=0 two cycles, then 1, no requests -> pc 0x0,0x4,0x8,0xC; flush=0.
//   2 Priority: at pc=0x10 assert branch 0x100, jump 0x200, jr 0x300 same cycle
//     -> next pc=0x300, flush=1 one cycle, then 0x304.
//   3 Stall buffering: stall=1 3 cycles at pc=0x20, branch 0x400 in cycle 1,
//     jump 0x500 in cycle 2 -> pc holds 0x20, pend_valid=1; release -> pc=0x500, flush=1.
//   4 Drop lower class: stall=1, jr 0x600 then branch 0x700 -> on release pc=0x600.
//   5 Exception + misalign: jr 0x1002 with stall=0 -> pc=0x1000, addr_err=1;
//     next cycle exc_req with jump 0x900 -> pc=0x80, addr_err=0.
//   6 Wrap/reset mid-op: pc=0xFFFF_FFFC no request -> pc=0x0; stall with pending,
//     rst_n=0 -> pc=RESET_PC, pend_valid=0, release yields sequential 0x4.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with fixed-priority redirect
// selection (exception > jump-register > jump > branch > sequential),
// fetch stall, and a one-entry buffer for redirects that arrive while stalled.
module pc_gen #(
  parameter int unsigned        WIDTH      = 32,
  parameter logic [WIDTH-1:0]   RESET_PC   = 32'h0000_0000,
  parameter logic [WIDTH-1:0]   EXC_VECTOR = 32'h0000_0080,
  parameter int unsigned        INCR       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             exc_req,
  input  logic             jr_valid,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             jump_valid,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             flush,
  output logic             addr_err,
  output logic             pend_valid
);

  typedef enum logic [1:0] {
    CLS_BR  = 2'd0,
    CLS_J   = 2'd1,
    CLS_JR  = 2'd2,
    CLS_EXC = 2'd3
  } cls_e;

  localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             addr_err_q, addr_err_d;
  logic             pend_valid_q, pend_valid_d;
  cls_e             pend_class_q, pend_class_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  logic             req_valid;
  cls_e             req_class;
  logic [WIDTH-1:0] req_target;
  logic             req_wins;
  logic [WIDTH-1:0] cand_target;

  // Pick the highest-priority incoming redirect this cycle.
  always_comb begin
    req_valid  = 1'b1;
    req_class  = CLS_BR;
    req_target = branch_target;
    if (exc_req) begin
      req_class  = CLS_EXC;
      req_target = EXC_VECTOR;
    end else if (jr_valid) begin
      req_class  = CLS_JR;
      req_target = jr_target;
    end else if (jump_valid) begin
      req_class  = CLS_J;
      req_target = jump_target;
    end else if (!branch_valid) begin
      req_valid  = 1'b0;
    end
  end

  // New request beats the buffered one when its class is higher or equal;
  // this single test serves both buffering during stall and release selection.
  assign req_wins = req_valid && (!pend_valid_q || (req_class >= pend_class_q));

  // Next-state for PC, status flags and the pending-redirect buffer.
  always_comb begin
    pc_d          = pc_q;
    flush_d       = 1'b0;
    addr_err_d    = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_class_d  = pend_class_q;
    pend_target_d = pend_target_q;
    cand_target   = req_wins ? req_target : pend_target_q;
    if (stall) begin
      if (req_wins) begin
        pend_valid_d  = 1'b1;
        pend_class_d  = req_class;
        pend_target_d = req_target;
      end
    end else begin
      pend_valid_d = 1'b0;
      if (req_wins || pend_valid_q) begin
        pc_d       = {cand_target[WIDTH-1:2], 2'b00};
        flush_d    = 1'b1;
        addr_err_d = |cand_target[1:0];
      end else begin
        pc_d = pc_q + INCR_W;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      addr_err_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_class_q  <= CLS_BR;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      addr_err_q    <= addr_err_d;
      pend_valid_q  <= pend_valid_d;
      pend_class_q  <= pend_class_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc          = pc_q;
  assign pc_next_seq = pc_q + INCR_W;
  assign flush       = flush_q;
  assign addr_err    = addr_err_q;
  assign pend_valid  = pend_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic for pc_gen, checked
// every cycle against a behavioural model of the redirect/stall rules.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n, stall, exc_req, jr_valid, jump_valid, branch_valid;
  logic [31:0] jr_target, jump_target, branch_target;
  logic [31:0] pc, pc_next_seq;
  logic        flush, addr_err, pend_valid;

  pc_gen #(
    .WIDTH      (32),
    .RESET_PC   (32'h0000_0000),
    .EXC_VECTOR (32'h0000_0080),
    .INCR       (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .exc_req       (exc_req),
    .jr_valid      (jr_valid),
    .jr_target     (jr_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .pc            (pc),
    .pc_next_seq   (pc_next_seq),
    .flush         (flush),
    .addr_err      (addr_err),
    .pend_valid    (pend_valid)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_flush, m_err, m_pv;
  int          m_pcls;
  logic [31:0] m_ptgt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one edge's worth of the architectural rules to the model.
  task automatic model_edge();
    int          rc, cc;
    logic [31:0] rt, ct;
    if (!rst_n) begin
      m_pc = 32'h0; m_flush = 0; m_err = 0; m_pv = 0;
      return;
    end
    rc = -1; rt = 32'h0;
    if (exc_req)           begin rc = 3; rt = 32'h80; end
    else if (jr_valid)     begin rc = 2; rt = jr_target; end
    else if (jump_valid)   begin rc = 1; rt = jump_target; end
    else if (branch_valid) begin rc = 0; rt = branch_target; end
    if (stall) begin
      m_flush = 0; m_err = 0;
      if (rc >= 0 && (!m_pv || rc >= m_pcls)) begin
        m_pv = 1; m_pcls = rc; m_ptgt = rt;
      end
    end else begin
      cc = -1; ct = 32'h0;
      if (m_pv) begin cc = m_pcls; ct = m_ptgt; end
      if (rc >= 0 && rc >= cc) begin cc = rc; ct = rt; end
      if (cc >= 0) begin
        m_pc    = ct / 4 * 4;
        m_flush = 1;
        m_err   = (ct % 4) != 0;
      end else begin
        m_pc    = m_pc + 32'd4;
        m_flush = 0;
        m_err   = 0;
      end
      m_pv = 0;
    end
  endtask

  task automatic step(input logic rn, input logic st, input logic ex,
                      input logic jrv, input logic [31:0] jrt,
                      input logic jv, input logic [31:0] jt,
                      input logic bv, input logic [31:0] bt);
    rst_n = rn; stall = st; exc_req = ex;
    jr_valid = jrv; jr_target = jrt;
    jump_valid = jv; jump_target = jt;
    branch_valid = bv; branch_target = bt;
    @(posedge clk);
    model_edge();
    #1;
    check("pc",          pc,                 m_pc);
    check("pc_next_seq", pc_next_seq,        m_pc + 32'd4);
    check("flush",       {31'b0, flush},     {31'b0, m_flush});
    check("addr_err",    {31'b0, addr_err},  {31'b0, m_err});
    check("pend_valid",  {31'b0, pend_valid},{31'b0, m_pv});
  endtask

  task automatic idle(input logic st);
    step(1, st, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // 1 reset then sequential fetch
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    for (int i = 0; i < 4; i++) idle(0);
    check("seq_pc", pc, 32'h10);

    // 2 priority: jr beats jump and branch
    step(1, 0, 0, 1, 32'h300, 1, 32'h200, 1, 32'h100);
    check("prio_pc", pc, 32'h300);
    check("prio_flush", {31'b0, flush}, 32'h1);
    idle(0);
    check("prio_seq", pc, 32'h304);

    // 3 stall buffering, jump supersedes branch
    step(1, 0, 0, 0, 0, 1, 32'h20, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 1, 32'h400);
    step(1, 1, 0, 0, 0, 1, 32'h500, 0, 0);
    idle(1);
    check("stall_hold", pc, 32'h20);
    check("stall_pend", {31'b0, pend_valid}, 32'h1);
    idle(0);
    check("release_pc", pc, 32'h500);
    check("release_flush", {31'b0, flush}, 32'h1);

    // 4 lower class dropped
    step(1, 1, 0, 1, 32'h600, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 1, 32'h700);
    idle(0);
    check("drop_pc", pc, 32'h600);

    // 5 misaligned target then exception
    step(1, 0, 0, 1, 32'h1002, 0, 0, 0, 0);
    check("mis_pc", pc, 32'h1000);
    check("mis_err", {31'b0, addr_err}, 32'h1);
    step(1, 0, 1, 0, 0, 1, 32'h900, 0, 0);
    check("exc_pc", pc, 32'h80);
    check("exc_err", {31'b0, addr_err}, 32'h0);

    // 6 wrap, then reset while stalled with a pending redirect
    step(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    idle(0);
    check("wrap_pc", pc, 32'h0);
    step(1, 1, 0, 1, 32'h700, 0, 0, 0, 0);
    check("pend_set", {31'b0, pend_valid}, 32'h1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_mid_pc", pc, 32'h0);
    check("rst_mid_pend", {31'b0, pend_valid}, 32'h0);
    idle(0);
    check("rst_mid_seq", pc, 32'h4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t0, t1, t2;
      t0 = $urandom; t1 = $urandom; t2 = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        t0[31:16] = 16'h0; t1[31:16] = 16'h0; t2[31:16] = 16'h0;
      end
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0), t0,
           ($urandom_range(0, 9) == 0), t1,
           ($urandom_range(0, 5) == 0), t2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
